// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    localparam logic [BE_W_DEF-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitrations a fetch lost to data.
// at_max tells the arbiter the fetch is owed the next grant.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'(MAX))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == 4'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one memory port.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);

    arb_state_t          state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_be_q;
    logic                kill_q;

    logic fetch_ok;
    logic starved;
    logic grant_d;
    logic grant_i;

    assign fetch_ok = if_req & ~if_kill;
    assign grant_d  = (state_q == IDLE) & d_req & ~starved;
    assign grant_i  = (state_q == IDLE) & ~grant_d & fetch_ok;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (grant_d & fetch_ok),
        .clr    (grant_i | if_kill),
        .at_max (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Payload registers only load on a grant, so they stay frozen while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            kill_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                    end else if (grant_i) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        mem_be_q   <= '1;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                    end else if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    kill_q    <= 1'b0;
                end
            endcase
        end
    end

    // A kill arriving in the ack cycle itself also swallows the done pulse.
    assign if_done = ~rst & (state_q == BUSY_I) & mem_ack & ~kill_q & ~if_kill;
    assign d_done  = ~rst & (state_q == BUSY_D) & mem_ack;

    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SMAX = 4;
  localparam int K_NONE = 0;
  localparam int K_FETCH = 1;
  localparam int K_DATA = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst;
  logic if_req, if_kill, if_done;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic d_req, d_we, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_be;
  logic stall_if, stall_mem;
  logic mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;
  logic [1:0] dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one outstanding transaction and what it carries
  int m_busy = K_NONE;
  bit m_killed = 1'b0;
  bit m_first = 1'b0;
  int m_cnt = 0;
  logic m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be = '0;
  logic [AW-1:0] exp_q[$];
  bit last_if_done, last_d_done;

  // check this cycle's outputs, advance the model, move to next negedge
  task automatic step();
    bit e_if_done, e_d_done, gd, gi, lost, starved;
    logic [AW-1:0] a;
    #1;
    e_if_done = !rst && m_busy == K_FETCH && mem_ack && !m_killed && !if_kill;
    e_d_done = !rst && m_busy == K_DATA && mem_ack;
    chk("mem_req", mem_req, m_busy != K_NONE);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_be", mem_be, m_be);
    chk("state", dbg_state, m_busy);
    chk("if_done", if_done, e_if_done);
    chk("d_done", d_done, e_d_done);
    chk("stall_if", stall_if, if_req && !e_if_done);
    chk("stall_mem", stall_mem, d_req && !e_d_done);
    if (e_if_done) chk("if_rdata", if_rdata, mem_rdata);
    if (e_d_done && !m_we) chk("d_rdata", d_rdata, mem_rdata);
    if (m_first) begin
      if (exp_q.size() == 0) chk("issue_q_empty", 1, 0);
      else begin
        a = exp_q.pop_front();
        chk("issue_addr", mem_addr, a);
      end
    end
    last_if_done = e_if_done;
    last_d_done = e_d_done;
    m_first = 1'b0;
    if (rst) begin
      m_busy = K_NONE; m_killed = 0; m_cnt = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      exp_q.delete();
    end else begin
      gd = 0; gi = 0; lost = 0;
      if (m_busy == K_NONE) begin
        starved = GUARD && m_cnt == SMAX;
        if (d_req && !starved) gd = 1;
        else if (if_req && !if_kill) gi = 1;
        lost = gd && if_req && !if_kill;
      end else if (mem_ack) begin
        m_busy = K_NONE; m_killed = 0;
      end else if (m_busy == K_FETCH && if_kill) begin
        m_killed = 1;
      end
      if (gd) begin
        m_busy = K_DATA; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
      end
      if (gi) begin
        m_busy = K_FETCH; m_we = 0; m_addr = if_addr; m_be = '1;
      end
      if (gd || gi) begin
        exp_q.push_back(m_addr);
        m_first = 1'b1;
      end
      if (if_kill || gi) m_cnt = 0;
      else if (lost && m_cnt < SMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req = 0; if_kill = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
  endtask

  int arb, first;

  initial begin
    rst = 1;
    quiet();
    mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    step();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_state", dbg_state, 0);
    rst = 0;
    step();

    // single load, ack two cycles after mem_req
    d_req = 1; d_we = 0; d_addr = 32'h100;
    step();
    step();
    step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_we", mem_we, 0);
    chk("ld_done", d_done, 1);
    chk("ld_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_stall", stall_mem, 0);
    step();
    quiet();
    step();

    // collision: store first, bubble, then fetch with all byte enables
    if_req = 1; if_addr = 32'h0;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
    step();
    #1;
    chk("col_we", mem_we, 1);
    chk("col_addr", mem_addr, 32'h200);
    chk("col_be", mem_be, 4'h3);
    mem_ack = 1;
    step();
    d_req = 0; mem_ack = 0;
    #1;
    chk("col_bubble", mem_req, 0);
    step();
    #1;
    chk("col_f_req", mem_req, 1);
    chk("col_f_addr", mem_addr, 32'h0);
    chk("col_f_be", mem_be, 4'hF);
    chk("col_f_we", mem_we, 0);
    mem_ack = 1;
    step();
    quiet();
    step();

    // kill while fetch in flight
    if_req = 1; if_addr = 32'h40;
    step();
    #1;
    chk("kill_addr", mem_addr, 32'h40);
    if_kill = 1;
    step();
    if_kill = 0; if_req = 0; mem_ack = 1;
    #1;
    chk("kill_no_done", if_done, 0);
    step();
    mem_ack = 0;
    step();
    if_req = 1; if_addr = 32'h44;
    step();
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("kill_next_done", if_done, 1);
    chk("kill_next_rdata", if_rdata, 32'hCAFEF00D);
    step();
    quiet();
    step();

    // reset during BUSY_D, then a stale ack
    d_req = 1; d_we = 0; d_addr = 32'h300;
    step();
    rst = 1; d_req = 0;
    step();
    rst = 0; mem_ack = 1;
    #1;
    chk("rmid_mem_req", mem_req, 0);
    chk("rmid_state", dbg_state, 0);
    chk("rmid_d_done", d_done, 0);
    chk("rmid_if_done", if_done, 0);
    step();
    mem_ack = 0;
    step();

    // starvation: continuous loads while a fetch waits
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 0; d_addr = 32'h400;
    arb = 0; first = 0;
    for (int c = 0; c < 40; c++) begin
      mem_ack = (m_busy != K_NONE);
      if (m_busy == K_NONE) arb++;
      step();
      if (m_busy == K_FETCH && first == 0) first = arb;
      if (last_if_done) if_req = 0;
    end
    chk("starve_first_grant", first, GUARD ? 5 : 0);
    quiet();
    step();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {$urandom_range(0, 1023), 2'b00};
      end
      if_kill = ($urandom_range(0, 15) == 0);
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1);
        d_addr = {$urandom_range(0, 1023), 2'b00};
        d_wdata = $urandom; d_be = $urandom_range(1, 15);
      end
      mem_ack = (m_busy != K_NONE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (last_if_done || if_kill) if_req = 0;
      if (last_d_done) d_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory port between the instruction-fetch stage and the MEM stage of the 32-bit pipeline. Fetch requests and decoded load/store requests (mem_read/mem_write from the control decode) are arbitrated by a three-state FSM with one outstanding transaction. Results return with a done pulse, and stall outputs hold the requesting stage. The block sits between the pipeline front/back ends and the memory controller.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch wins; range 1..15

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done or if_kill
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_kill  in  1  pipeline flush; discards a pending or in-flight fetch
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request (mem_read | mem_write); held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_done  out  1  one-cycle pulse; d_rdata valid for loads
- d_rdata  out  DATA_W  load data
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  d_req & ~d_done
- mem_req  out  1  registered; held high for the whole transaction
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered transaction payload
- mem_ack  in  1  memory completion; read data valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req is high and the fetch is not starved, latch the data payload and go to BUSY_D.
  - Otherwise, if if_req & ~if_kill, latch the fetch payload (mem_we=0, mem_be=all ones) and go to BUSY_I.
  - Otherwise stay in IDLE.
- BUSY_x: mem_req=1 and the payload stays frozen. When mem_ack=1, pulse the matching done output combinationally, drive rdata from mem_rdata, and return to IDLE.
- mem_ack in IDLE is ignored, including a stale ack after reset.
- if_kill in BUSY_I: the transaction still completes on the memory side. A kill flag is set, and if_done is suppressed for that transaction. The flag clears when the FSM returns to IDLE.
- if_kill in IDLE blocks a fetch grant in that cycle only.
- Data priority is strict, subject to the starvation guard in Configuration.
- if_rdata and d_rdata are combinational pass-throughs of mem_rdata. They are defined only during the corresponding done pulse.

## Timing
- Reset values:
  - FSM state = IDLE.
  - mem_req, mem_we, if_done, d_done = 0.
  - mem_addr, mem_wdata, mem_be = 0.
  - Starvation count and kill flag = 0.
- Latency:
  - Request sampled in IDLE at cycle N; mem_req=1 from cycle N+1.
  - Earliest mem_ack is at N+1, giving done at N+1 (minimum 1-cycle request-to-done).
  - There is a mandatory one-cycle IDLE bubble between back-to-back transactions.
- Simultaneous if_req and d_req in IDLE: data wins unless the starvation guard fires.
- rst asserted mid-transaction: the FSM is in IDLE and mem_req=0 after that edge, no done pulse is produced, and the requester re-requests.
- stall_if and stall_mem are combinational. They are low in the done cycle, so the pipeline advances on that edge.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments each IDLE arbitration in which if_req & ~if_kill lost to d_req, saturating at STARVE_MAX.
  - When count == STARVE_MAX, fetch wins the next IDLE arbitration.
  - The counter clears on any fetch grant and on if_kill.
- ARB_STARVE_GUARD_EN not defined: the counter logic is absent and data has strict priority. A continuous d_req can starve fetch indefinitely; this is accepted.

## Structure
- Shared package cpu_mem_pkg holds:
  - the state enumeration (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - the ADDR_W and DATA_W default constants;
  - the all-ones byte-enable constant.
- Sub-module arb_starve_ctr is natural: saturating counter with inc, clr and limit-reached output. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Single load:
  - Stimulus: d_req=1, d_we=0, d_addr=0x100; memory acks 2 cycles after mem_req with 0xDEADBEEF.
  - Response: mem_addr=0x100, mem_we=0; d_done pulses once with d_rdata=0xDEADBEEF; stall_mem is low in that cycle.
- Collision:
  - Stimulus: if_req (0x0) and d_req store (0x200, wdata 0x12345678, be 0x3) rise in the same cycle.
  - Response: the store is issued first. After its ack there is one IDLE bubble, then the fetch is issued with mem_be=0xF.
- Kill in flight:
  - Stimulus: fetch 0x40 in BUSY_I, if_kill pulsed before mem_ack.
  - Response: the transaction completes, if_done never pulses, and the next fetch behaves normally.
- Starvation (macro defined, STARVE_MAX=4):
  - Stimulus: d_req held continuously with memory acking, if_req high.
  - Response: the fetch is granted on the 5th arbitration. Without the macro, no fetch grant ever occurs.
- Reset mid-op:
  - Stimulus: rst for one cycle during BUSY_D, then a stale mem_ack one cycle later.
  - Response: the FSM is in IDLE, mem_req=0, neither done output pulses, and the stale ack is ignored.
